// File: rtl/net_frame_ctrl.sv
// Frame sequencer in front of net_proc: loads one frame of pixel bytes into its memory,
// launches a run, waits for done (or the watchdog) and returns the winning class index.
module net_frame_ctrl #(
    parameter int FRAME_LEN      = 784,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        ext_mem_rst,
    output logic        ext_mem_we,
    output logic [7:0]  ext_mem_wdata,
    output logic        start,
    input  logic        done,
    input  logic [3:0]  max_idx_10,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_idx,
    output logic        res_timeout,
    output logic        busy,
    output logic [15:0] frames_done
);

    localparam int BW = $clog2(FRAME_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] LAST_BYTE  = BW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GUARD_LAST = TW'(1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLR    = 3'd1;
    localparam logic [2:0] S_LOAD   = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_GUARD  = 3'd5;
    localparam logic [2:0] S_RUN    = 3'd6;
    localparam logic [2:0] S_RESULT = 3'd7;

    logic [2:0]    state;
    logic [BW-1:0] byte_cnt;
    logic [TW-1:0] tmo_cnt;

    // Outputs are registered alongside the state, so each is set on the edge entering
    // the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            byte_cnt      <= '0;
            tmo_cnt       <= '0;
            s_ready       <= 1'b0;
            ext_mem_rst   <= 1'b0;
            ext_mem_we    <= 1'b0;
            ext_mem_wdata <= '0;
            start         <= 1'b0;
            res_valid     <= 1'b0;
            res_idx       <= '0;
            res_timeout   <= 1'b0;
            busy          <= 1'b0;
            frames_done   <= '0;
        end else begin
            ext_mem_rst <= 1'b0;
            ext_mem_we  <= 1'b0;
            start       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s_valid) begin
                        state       <= S_CLR;
                        ext_mem_rst <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_CLR: begin
                    byte_cnt <= '0;
                    s_ready  <= 1'b1;
                    state    <= S_LOAD;
                end
                S_LOAD: begin
                    if (s_valid && s_ready) begin
                        ext_mem_we    <= 1'b1;
                        ext_mem_wdata <= s_data;
                        byte_cnt      <= byte_cnt + 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            s_ready <= 1'b0;
                            state   <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    start <= 1'b1;
                    state <= S_START;
                end
                S_START: begin
                    tmo_cnt <= '0;
                    state   <= S_GUARD;
                end
                // done may still be high from the previous run; only the watchdog counts here
                S_GUARD: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (tmo_cnt == GUARD_LAST) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (done) begin
                        res_valid   <= 1'b1;
                        res_idx     <= max_idx_10;
                        res_timeout <= 1'b0;
                        state       <= S_RESULT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_valid   <= 1'b1;
                        res_idx     <= 4'hF;
                        res_timeout <= 1'b1;
                        state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid   <= 1'b0;
                        frames_done <= frames_done + 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_net_frame_ctrl.sv
// Directed bench for net_frame_ctrl: write and result scoreboards plus cycle-position checks.
// A second instance with a short watchdog covers the timeout path.
module tb_net_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, s_valid, s_ready, ext_mem_rst, ext_mem_we, start, done;
    logic [7:0]  s_data, ext_mem_wdata;
    logic [3:0]  max_idx_10, res_idx;
    logic        res_valid, res_ready, res_timeout, busy;
    logic [15:0] frames_done;

    logic        s_valid_t, s_ready_t, ext_mem_rst_t, ext_mem_we_t, start_t;
    logic [7:0]  ext_mem_wdata_t;
    logic [3:0]  res_idx_t;
    logic        res_valid_t, res_ready_t, res_timeout_t, busy_t;
    logic [15:0] frames_done_t;
    logic        done_t = 1'b0;
    logic [3:0]  max_idx_t = 4'd9;

    net_frame_ctrl #(.FRAME_LEN(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ext_mem_rst(ext_mem_rst), .ext_mem_we(ext_mem_we), .ext_mem_wdata(ext_mem_wdata),
        .start(start), .done(done), .max_idx_10(max_idx_10),
        .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
        .res_timeout(res_timeout), .busy(busy), .frames_done(frames_done)
    );

    net_frame_ctrl #(.FRAME_LEN(4), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .rst(rst), .s_valid(s_valid_t), .s_ready(s_ready_t), .s_data(s_data),
        .ext_mem_rst(ext_mem_rst_t), .ext_mem_we(ext_mem_we_t), .ext_mem_wdata(ext_mem_wdata_t),
        .start(start_t), .done(done_t), .max_idx_10(max_idx_t),
        .res_valid(res_valid_t), .res_ready(res_ready_t), .res_idx(res_idx_t),
        .res_timeout(res_timeout_t), .busy(busy_t), .frames_done(frames_done_t)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rst, n_we, n_start, rst_c, first_we_c, last_we_c, start_c, s_c;
    logic [7:0] wq[$];
    logic [4:0] rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_rst = 0; n_we = 0; n_start = 0;
    endtask

    // Monitor samples 2 time units after each edge, after the stimulus has settled.
    always @(posedge clk) begin
        #2;
        if (ext_mem_rst) begin
            n_rst++;
            rst_c = cyc;
        end
        if (ext_mem_we) begin
            if (n_we == 0) first_we_c = cyc;
            n_we++;
            last_we_c = cyc;
            check("wr_pending", 32'(wq.size() != 0), 1);
            if (wq.size() != 0) check("wdata", ext_mem_wdata, wq.pop_front());
        end
        if (start) begin
            n_start++;
            start_c = cyc;
            check("start_excl", {ext_mem_we, ext_mem_rst}, 0);
        end
        if (res_valid && res_ready) begin
            check("res_pending", 32'(rq.size() != 0), 1);
            if (rq.size() != 0) check("result", {res_timeout, res_idx}, rq.pop_front());
        end
    end

    task automatic send(input bit sel, input logic [7:0] base, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            int w;
            logic [7:0] d;
            w = 0;
            d = base + 8'(i * 10);
            s_data = d;
            if (sel) s_valid_t = 1'b1; else s_valid = 1'b1;
            while (!(sel ? s_ready_t : s_ready) && w < 50) begin
                tick();
                w++;
            end
            check("hs_seen", sel ? s_ready_t : s_ready, 1);
            if (!sel) wq.push_back(d);
            tick();
            if (gap) begin
                s_valid = 1'b0; s_valid_t = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0; s_valid_t = 1'b0;
    endtask

    task automatic wait_start(input bit sel);
        int w;
        w = 0;
        while (!(sel ? start_t : start) && w < 100) begin
            tick();
            w++;
        end
        check("start_seen", sel ? start_t : start, 1);
        s_c = cyc;
    endtask

    task automatic wait_res(input int lat);
        int w;
        w = 0;
        while (!res_valid && w < 200) begin
            tick();
            w++;
        end
        check("res_seen", res_valid, 1);
        check("res_lat", 32'(cyc - s_c), 32'(lat));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_valid_t = 1'b0; s_data = '0;
        done = 1'b0; max_idx_10 = '0; res_ready = 1'b1; res_ready_t = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", {s_ready, busy, res_valid, ext_mem_rst, ext_mem_we, start, res_timeout, res_idx}, 0);
        check("rst_cnt", {ext_mem_wdata, frames_done}, 0);
        check("rst_ctrl_t", {s_ready_t, busy_t, res_valid_t, start_t, res_timeout_t, res_idx_t, frames_done_t}, 0);
        rst = 1'b0;
        tick();

        // Back-to-back frame, then done 20 cycles after start
        clear_mon();
        send(0, 8'd10, 4, 0);
        wait_start(0);
        repeat (20) tick();
        done = 1'b1; max_idx_10 = 4'd7;
        rq.push_back({1'b0, 4'd7});
        wait_res(21);
        tick();
        check("res_one_cycle", res_valid, 0);
        check("frames_1", frames_done, 1);
        check("t1_n_rst", n_rst, 1);
        check("t1_n_we", n_we, 4);
        check("t1_clr_to_we", 32'(first_we_c - rst_c), 2);
        check("t1_we_span", 32'(last_we_c - first_we_c), 3);
        check("t1_we_to_start", 32'(start_c - last_we_c), 1);
        check("t1_n_start", n_start, 1);

        // Gapped frame with a stale done held high into the guard window
        clear_mon();
        max_idx_10 = 4'd12;
        send(0, 8'd50, 4, 1);
        s_valid = 1'b1; s_data = 8'd99;
        check("extra_held", s_ready, 0);
        wait_start(0);
        check("extra_held2", s_ready, 0);
        s_valid = 1'b0;
        repeat (3) tick();
        done = 1'b0; max_idx_10 = 4'd3;
        repeat (10) tick();
        done = 1'b1;
        rq.push_back({1'b0, 4'd3});
        wait_res(14);
        tick();
        done = 1'b0;
        check("frames_2", frames_done, 2);
        check("t2_n_we", n_we, 4);
        check("t2_gap_span", 32'(last_we_c - first_we_c), 6);
        check("t2_n_rst", n_rst, 1);

        // Watchdog instance: done never arrives
        send(1, 8'd1, 4, 0);
        wait_start(1);
        repeat (16) tick();
        check("tmo_early", res_valid_t, 0);
        tick();
        check("tmo_fire", {res_valid_t, res_timeout_t, res_idx_t}, {1'b1, 1'b1, 4'hF});
        repeat (5) begin
            tick();
            check("tmo_hold", {res_valid_t, res_timeout_t, res_idx_t}, {1'b1, 1'b1, 4'hF});
        end
        res_ready_t = 1'b1;
        tick();
        check("tmo_ack", res_valid_t, 0);
        check("tmo_frames", frames_done_t, 1);

        // Reset mid-frame, then a fresh full frame
        clear_mon();
        send(0, 8'd100, 2, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ctrl", {s_ready, busy, res_valid, ext_mem_rst, ext_mem_we, start, res_timeout, res_idx}, 0);
        check("mid_rst_cnt", {ext_mem_wdata, frames_done}, 0);
        check("mid_rst_wq", 32'(wq.size()), 0);
        clear_mon();
        send(0, 8'd200, 4, 0);
        wait_start(0);
        repeat (5) tick();
        done = 1'b1; max_idx_10 = 4'd5;
        rq.push_back({1'b0, 4'd5});
        wait_res(6);
        tick();
        done = 1'b0;
        check("t6_frames", frames_done, 1);
        check("t6_n_rst", n_rst, 1);
        check("t6_n_we", n_we, 4);
        check("t6_rq_empty", 32'(rq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
